// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared encodings, defaults and helpers for the shift-and-add multiplier
package mult_pkg;

    localparam int DEF_N  = 8;
    localparam int DEF_CW = 4;

    // 2'b11 is never entered; it behaves like IDLE so a corrupted state recovers.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10,
        S_RSVD = 2'b11
    } state_t;

    // One iteration per multiplier bit.
    function automatic int cnt_reload(input int n);
        return n;
    endfunction

endpackage

// File: rtl/mult_prims.sv
// rtl/mult_prims.sv - sync-reset enabled register and 2x1 mux primitives
module sync_reg #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

module mux2 #(
    parameter int W = 1
) (
    input  logic         sel_i,
    input  logic [W-1:0] in0_i,
    input  logic [W-1:0] in1_i,
    output logic [W-1:0] out_o
);

    assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/shift_add_dp.sv
// rtl/shift_add_dp.sv - multiplicand register, {acc, q} shift register and (N+1)-bit adder
import mult_pkg::*;

module shift_add_dp #(
    parameter int N = DEF_N
) (
    input  logic           clk_i,
    input  logic           clear_i,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] product_o
);

    logic [N-1:0] mcand_q;
    logic [N-1:0] acc_q;
    logic [N-1:0] q_q;
    logic [N-1:0] acc_d;
    logic [N-1:0] q_d;
    logic [N-1:0] addend;
    logic [N:0]   sum;
    logic         shift_en;

    assign shift_en = load_i | step_i;

    sync_reg #(.W(N)) u_mcand (
        .clk_i (clk_i),
        .rst_i (clear_i),
        .en_i  (load_i),
        .d_i   (a_i),
        .q_o   (mcand_q)
    );

    mux2 #(.W(N)) u_addend (
        .sel_i (q_q[0]),
        .in0_i ({N{1'b0}}),
        .in1_i (mcand_q),
        .out_o (addend)
    );

    // The carry lives in sum[N]; shifting it into acc[N-1] means no separate carry flop is needed.
    assign sum = {1'b0, acc_q} + {1'b0, addend};

    mux2 #(.W(N)) u_acc_sel (
        .sel_i (load_i),
        .in0_i (sum[N:1]),
        .in1_i ({N{1'b0}}),
        .out_o (acc_d)
    );

    mux2 #(.W(N)) u_q_sel (
        .sel_i (load_i),
        .in0_i ({sum[0], q_q[N-1:1]}),
        .in1_i (b_i),
        .out_o (q_d)
    );

    sync_reg #(.W(N)) u_acc (
        .clk_i (clk_i),
        .rst_i (clear_i),
        .en_i  (shift_en),
        .d_i   (acc_d),
        .q_o   (acc_q)
    );

    sync_reg #(.W(N)) u_q (
        .clk_i (clk_i),
        .rst_i (clear_i),
        .en_i  (shift_en),
        .d_i   (q_d),
        .q_o   (q_q)
    );

    assign product_o = {acc_q, q_q};

endmodule

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - start/done sequential unsigned multiplier: FSM, counter and datapath
import mult_pkg::*;

module shift_add_mult #(
    parameter int N  = DEF_N,
    parameter int CW = DEF_CW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          busy_q;
    logic          done_q;
    logic          idle;
    logic          dp_load;
    logic          dp_step;

    assign cnt_d   = cnt_q - CW'(1);
    assign idle    = (state_q != S_CALC) && (state_q != S_DONE);
    assign dp_load = idle && start;
    assign dp_step = (state_q == S_CALC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_CALC: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    if (start) begin
                        state_q <= S_CALC;
                        cnt_q   <= CW'(cnt_reload(N));
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // rst doubles as the datapath clear so an aborted product reads zero next cycle.
    shift_add_dp #(.N(N)) u_dp (
        .clk_i     (clk),
        .clear_i   (rst),
        .load_i    (dp_load),
        .step_i    (dp_step),
        .a_i       (a),
        .b_i       (b),
        .product_o (product)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// tb/tb_shift_add_mult.sv - scoreboard bench for shift_add_mult
module tb_shift_add_mult;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic          busy;
    logic          done;
    logic [2*N-1:0] product;

    typedef struct {
        logic [2*N-1:0] prod;
        int             cyc;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_count = 0;

    bit             prev_done = 1'b0;
    bit             prev_busy = 1'b0;
    bit             rst_at_edge = 1'b1;
    bit             hold_pending = 1'b0;
    logic [2*N-1:0] hold_val = '0;
    bit             cont_mode = 1'b0;
    bit             cont_prev_valid = 1'b0;
    int             last_done_cyc = 0;

    shift_add_mult dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            done_count++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending result", cyc);
            end else begin
                e = sb.pop_front();
                checks++;
                if (product !== e.prod) begin
                    failures++;
                    $display("FAIL product: got %h, required %h", product, e.prod);
                end
                checks++;
                if (cyc != e.cyc) begin
                    failures++;
                    $display("FAIL latency: done at cycle %0d, required %0d", cyc, e.cyc);
                end
                checks++;
                if (prev_done || !busy) begin
                    failures++;
                    $display("FAIL done_pulse: prev_done=%0d busy=%0d, required 0 and 1", prev_done, busy);
                end
                hold_pending = 1'b1;
                hold_val     = e.prod;
            end
            if (cont_mode) begin
                if (cont_prev_valid) begin
                    checks++;
                    if (cyc - last_done_cyc != N + 2) begin
                        failures++;
                        $display("FAIL period: %0d cycles between done, required %0d", cyc - last_done_cyc, N + 2);
                    end
                end
                cont_prev_valid = 1'b1;
            end
            last_done_cyc = cyc;
        end else if (hold_pending) begin
            hold_pending = 1'b0;
            checks++;
            if (product !== hold_val || busy !== 1'b0) begin
                failures++;
                $display("FAIL hold: product=%h busy=%0d, required %h and 0", product, busy, hold_val);
            end
        end
        if (prev_busy && !busy && !prev_done && !rst_at_edge) begin
            checks++;
            failures++;
            $display("FAIL busy_drop: busy fell at cycle %0d without done", cyc);
        end
        prev_done = done;
        prev_busy = busy;
    end

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Waits for an idle cycle, presents one start and queues its expected result.
    task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv,
                         input logic [2*N-1:0] expv, input bit hold);
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: busy stuck high, required 0 within 100 cycles");
            return;
        end
        a     = av;
        b     = bv;
        start = 1'b1;
        sb.push_back('{prod: expv, cyc: cyc + 1 + N});
        @(negedge clk);
        if (!hold) start = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results pending, required 0", sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int dc;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        repeat (3) @(negedge clk);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_product", 32'(product), 32'd0);
        rst = 1'b0;

        issue(8'hFF, 8'hFF, 16'hFE01, 1'b0);
        check_eq("busy_after_start", 32'(busy), 32'd1);
        drain();
        check_eq("held_in_idle", 32'(product), 32'hFE01);

        issue(8'h0D, 8'h0B, 16'h008F, 1'b0);
        issue(8'h00, 8'h5A, 16'h0000, 1'b0);
        issue(8'h01, 8'hFF, 16'h00FF, 1'b0);
        issue(8'h80, 8'h80, 16'h4000, 1'b0);
        drain();

        cont_mode       = 1'b1;
        cont_prev_valid = 1'b0;
        for (int i = 0; i < 3; i++) issue(8'd3, 8'd5, 16'h000F, 1'b1);
        start = 1'b0;
        drain();
        cont_mode = 1'b0;

        @(negedge clk);
        a     = 8'h80;
        b     = 8'h02;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_product", 32'(product), 32'd0);
        rst = 1'b0;
        dc  = done_count;
        repeat (15) @(negedge clk);
        check_eq("abort_no_done", 32'(done_count), 32'(dc));
        issue(8'd2, 8'd2, 16'h0004, 1'b0);
        drain();

        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h22;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_eq("rst_wins_busy", 32'(busy), 32'd0);
        check_eq("rst_wins_product", 32'(product), 32'd0);
        issue(8'h11, 8'h22, 16'h0242, 1'b0);
        drain();

        for (int i = 0; i < 1000; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            issue(ra, rb, (2*N)'(ra) * (2*N)'(rb), 1'b0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

// File: doc/shift_add_mult.md
Name: shift_add_mult

Overview:
- Sequential unsigned N x N multiplier controller and datapath using the shift-and-add method.
- One N-bit add per cycle into an (N+1)-bit accumulator, followed by a right shift of {carry, accumulator, multiplier}.
- Sits beside the 8-bit ALU as the multi-cycle arithmetic unit for MUL-type operations.
- Interface is start/done, so a processor control unit can stall on busy.

Parameters:
- N, 8, operand width in bits; product width is 2N.
- CW, 4, iteration counter width; must satisfy 2^CW > N.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only when busy=0
- a  input  N  multiplicand; captured on accepted start
- b  input  N  multiplier; captured on accepted start
- busy  output  1  high while an operation is in progress (states CALC and DONE)
- done  output  1  single-cycle pulse; product valid from this cycle onward
- product  output  2N  result {acc, q}; held until next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, product=0, counter=0, all internal registers 0.
- States:
  - IDLE: busy=0. On start=1 at an edge: mcand<=a, q<=b, acc<=0, carry<=0, counter<=N, next state CALC.
  - CALC: busy=1. Each edge:
    - sum = acc + (q[0] ? mcand : 0), computed (N+1) bits wide.
    - {carry, acc, q} <= {1'b0, sum, q} >> 1, i.e. acc <= sum[N:1], q <= {sum[0], q[N-1:1]}.
    - counter <= counter-1.
    - When counter==1 at the edge, next state is DONE.
  - DONE: busy=1, done=1 for exactly this one cycle. Next edge returns to IDLE unconditionally.
- Start handling:
  - start in CALC or DONE is ignored; there is no queuing.
  - Back-to-back: start asserted in the first IDLE cycle after DONE is accepted.
- Latency: start sampled at edge k gives CALC for edges k+1..k+N. done is high in the cycle following edge k+N. Throughput is one result per N+2 cycles.
- No early termination: zero operands still take N iterations.
- Width rules:
  - Carry out of the add is kept in the sum MSB; no overflow is possible.
  - Maximum result: (2^N-1)^2 = 0xFE01 for N=8.
- product is a combinational view of {acc, q}.
  - During CALC it is intermediate; consumers must use it only at or after done.
  - After DONE it holds the final value through IDLE until the next accepted start reloads acc=0, q=b.
- Reset mid-operation: on the rst edge, state returns to IDLE. busy, done and product clear on the next cycle. No done pulse is issued for the aborted operation.
- start and rst high together: rst wins.
- Inputs a and b may change freely after the start edge; they are not re-sampled.

Decomposition:
- Shared package mult_pkg holds:
  - state encoding constants S_IDLE=2'b00, S_CALC=2'b01, S_DONE=2'b10 (2'b11 decodes to IDLE);
  - default N and CW;
  - function for the counter reload value.
- One sub-module: shift_add_dp. It contains the mcand register, the {acc, q} shift register with parallel load, the (N+1)-bit adder and the q[0] operand mux.
- The shift_add_mult top contains the FSM and counter, and drives dp controls load, step and clear.
- shift_add_dp is built from the existing sync-reset register and 2x1 mux primitives where practical.

Test Plan:
- a=0xFF, b=0xFF, start pulse at edge 0 -> busy=1 from cycle 1; done=1 only in cycle 9; product=0xFE01 in cycle 9 and held in IDLE.
- a=0x0D, b=0x0B -> product=0x008F at done. Then a=0x00, b=0x5A -> product=0x0000, still exactly N+1 cycles to done.
- start held high continuously, a=3, b=5 -> results 0x000F with done pulses every N+2=10 cycles. Changing a/b during CALC has no effect on the in-flight result.
- Reset mid-op: start a=0x80, b=0x02; rst=1 at 4th CALC edge -> following cycle busy=0, done=0, product=0. No done pulse follows. A new start a=2, b=2 then gives 0x0004.
- rst and start both high in IDLE -> remains IDLE, busy=0. Then start alone is accepted normally.
- Randomized: 1000 random a/b pairs checked against a*b; assert done is a one-cycle pulse and busy never drops before done.
